pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MA/WB).
- Owns the run/halt state of the CPU and generates pipeline flush (rst_pipe).
- Generates the global stall, its one-shot and delayed forms, and the load-use stall pair consumed by the ID stage's register-file rollback logic.
- Sits beside the ID stage: takes its forwarding outputs and the EX-stage load/destination state, and drives the stall inputs of every stage.

Parameters:
FLUSH_CYCLES, 4, cycles rst_pipe is held when starting the CPU (1..15)
DRAIN_CYCLES, 3, cycles allowed for MA/WB to retire after a stop request (1..15)
BOOT_RUN, 0, 1 = leave reset into FLUSH (auto-start); 0 = leave reset into HALT

Ports:
clk  in  1  core clock
rst_n  in  1  reset
cpu_start  in  1  start request pulse from debug/monitor
cpu_stop  in  1  stop request pulse from debug/monitor
dmem_wait  in  1  external stall request (data memory / IO busy)
inst_rs1_id  in  5  rs1 number of instruction in ID
inst_rs2_id  in  5  rs2 number of instruction in ID
inst_rs1_valid  in  1  ID instruction reads rs1
inst_rs2_valid  in  1  ID instruction reads rs2
cmd_ld_ex  in  1  EX holds a load
rd_adr_ex  in  5  EX destination register
wbk_rd_reg_ex  in  1  EX instruction writes rd
jmp_purge_ma  in  1  taken jump/branch purging younger instructions
stall  out  1  global pipeline hold
stall_1shot  out  1  first cycle of a stall episode
stall_dly  out  1  stall delayed by one cycle
stall_ld  out  1  load-use bubble request
stall_ld_ex  out  1  stall_ld delayed by one cycle
rst_pipe  out  1  synchronous pipeline flush
cpu_running  out  1  state == RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values:
  - state = HALT (FLUSH if BOOT_RUN = 1).
  - counter = 0; stall_q = 1; stall_ld_ex = 0.
  - Outputs: stall = 1, stall_1shot = 0, stall_dly = 1, rst_pipe = 0 (1 if BOOT_RUN), cpu_running = 0, stall_ld = 0.
- State machine, states HALT, FLUSH, RUN, DRAIN:
  - HALT:
    - cpu_start & ~cpu_stop -> FLUSH, counter loaded with FLUSH_CYCLES-1.
    - Otherwise stay in HALT.
  - FLUSH:
    - rst_pipe = 1.
    - counter == 0 -> RUN; otherwise decrement.
    - cpu_stop -> HALT next cycle; this aborts the flush.
  - RUN:
    - cpu_stop -> DRAIN, counter loaded with DRAIN_CYCLES-1.
    - cpu_start is ignored.
  - DRAIN:
    - Pipeline keeps running; front end is held via stall.
    - counter == 0 -> HALT.
    - cpu_start and cpu_stop are ignored.
  - cpu_start and cpu_stop in the same cycle: stop wins.
- Global stall (combinational):
  - stall = dmem_wait | (state == HALT) | (state == FLUSH) | (state == DRAIN).
  - stall_q is a register: stall_q <= stall every cycle.
  - stall_1shot = stall & ~stall_q.
  - stall_dly = stall_q.
  - rst_pipe forces stall_q <= 1, so the first RUN cycle after a flush produces no spurious 1shot.
- Load-use hazard (combinational):
  - hazard = cmd_ld_ex & wbk_rd_reg_ex & (rd_adr_ex != 0) & ((inst_rs1_valid & inst_rs1_id == rd_adr_ex) | (inst_rs2_valid & inst_rs2_id == rd_adr_ex)).
  - stall_ld = hazard & (state == RUN) & ~stall & ~jmp_purge_ma.
  - It self-clears next cycle because ID inserts a bubble (cmd_ld_ex = 0).
- stall_ld_ex register:
  - stall_ld_ex <= stall_ld when ~stall; holds when stall.
  - Cleared to 0 when rst_pipe = 1.
- stall_ld and stall are never both 1.
- rst_pipe is combinational from state, so a flush starts the cycle after cpu_start is sampled.
- Reset asserted mid-FLUSH or mid-DRAIN returns the block to its reset state on the next edge; no partial counts survive.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state encoding (2-bit: HALT = 0, FLUSH = 1, RUN = 2, DRAIN = 3);
  - the counter width constant (4).
- Natural sub-module: ld_hazard_det, the purely combinational hazard compare. It is reusable by a future forwarding unit.
- FSM, counter and delay registers stay in the top module.

Test Plan:
- Reset with BOOT_RUN = 0, pulse cpu_start at cycle 5 -> rst_pipe = 1 for cycles 6..9, RUN and cpu_running = 1 at cycle 10, stall falls at cycle 10, stall_dly falls at cycle 11, no stall_1shot at cycle 10.
- In RUN: cmd_ld_ex = 1, rd_adr_ex = 5, wbk_rd_reg_ex = 1, inst_rs2_id = 5, inst_rs2_valid = 1 -> stall_ld = 1 for exactly that cycle, stall_ld_ex = 1 the next cycle. Repeat with rd_adr_ex = 0 or inst_rs2_valid = 0 -> stall_ld = 0.
- Same hazard with jmp_purge_ma = 1 or dmem_wait = 1 -> stall_ld = 0.
- In RUN: dmem_wait high for 3 cycles (t..t+2) -> stall = 1 at t..t+2, stall_1shot = 1 only at t, stall_dly = 1 at t+1..t+3.
- In RUN: pulse cpu_stop -> DRAIN for 3 cycles with stall = 1, then HALT. cpu_start during DRAIN has no effect. cpu_start and cpu_stop together in HALT -> stays in HALT.
- cpu_stop at the 2nd FLUSH cycle -> HALT next cycle and rst_pipe drops. rst_n low mid-FLUSH -> next edge shows HALT, rst_pipe = 0, stall_ld_ex = 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: run-state encoding
// and counter width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StFlush = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam int unsigned CntW = 4;

endpackage

// File: rtl/ld_hazard_det.sv
// Load-use hazard compare: the instruction in ID reads a register that the load in EX
// has not produced yet.
module ld_hazard_det (
  input  logic       i_cmd_ld_ex,
  input  logic [4:0] i_rd_adr_ex,
  input  logic       i_wbk_rd_reg_ex,
  input  logic [4:0] i_inst_rs1_id,
  input  logic [4:0] i_inst_rs2_id,
  input  logic       i_inst_rs1_valid,
  input  logic       i_inst_rs2_valid,
  output logic       o_hazard
);

  logic w_ld_writes;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_ld_writes = i_cmd_ld_ex & i_wbk_rd_reg_ex & (i_rd_adr_ex != 5'd0);
  assign w_rs1_hit   = i_inst_rs1_valid & (i_inst_rs1_id == i_rd_adr_ex);
  assign w_rs2_hit   = i_inst_rs2_valid & (i_inst_rs2_id == i_rd_adr_ex);
  assign o_hazard    = w_ld_writes & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: owns CPU run/halt state, pipeline flush, the global
// stall family and the load-use stall pair for the 5-stage core.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter bit          BOOT_RUN     = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cpu_start,
  input  logic       i_cpu_stop,
  input  logic       i_dmem_wait,
  input  logic [4:0] i_inst_rs1_id,
  input  logic [4:0] i_inst_rs2_id,
  input  logic       i_inst_rs1_valid,
  input  logic       i_inst_rs2_valid,
  input  logic       i_cmd_ld_ex,
  input  logic [4:0] i_rd_adr_ex,
  input  logic       i_wbk_rd_reg_ex,
  input  logic       i_jmp_purge_ma,
  output logic       o_stall,
  output logic       o_stall_1shot,
  output logic       o_stall_dly,
  output logic       o_stall_ld,
  output logic       o_stall_ld_ex,
  output logic       o_rst_pipe,
  output logic       o_cpu_running
);

  localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_CYCLES - 1);
  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES - 1);
  localparam state_e          RstState  = BOOT_RUN ? StFlush : StHalt;

  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_stall_q;
  logic            w_stall_q_d;
  logic            r_stall_ld_ex;
  logic            w_stall_ld_ex_d;
  logic            w_hazard;
  logic            w_stall;
  logic            w_stall_ld;
  logic            w_rst_pipe;

  ld_hazard_det u_ld_hazard_det (
    .i_cmd_ld_ex      (i_cmd_ld_ex),
    .i_rd_adr_ex      (i_rd_adr_ex),
    .i_wbk_rd_reg_ex  (i_wbk_rd_reg_ex),
    .i_inst_rs1_id    (i_inst_rs1_id),
    .i_inst_rs2_id    (i_inst_rs2_id),
    .i_inst_rs1_valid (i_inst_rs1_valid),
    .i_inst_rs2_valid (i_inst_rs2_valid),
    .o_hazard         (w_hazard)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StHalt: begin
        if (i_cpu_start && !i_cpu_stop) begin
          w_state_d = StFlush;
          w_cnt_d   = FlushLoad;
        end
      end
      StFlush: begin
        if (i_cpu_stop) begin
          w_state_d = StHalt;
        end else if (r_cnt == '0) begin
          w_state_d = StRun;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StRun: begin
        if (i_cpu_stop) begin
          w_state_d = StDrain;
          w_cnt_d   = DrainLoad;
        end
      end
      StDrain: begin
        if (r_cnt == '0) begin
          w_state_d = StHalt;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      default: w_state_d = StHalt;
    endcase
  end

  assign w_rst_pipe = (r_state == StFlush);
  assign w_stall    = i_dmem_wait | (r_state != StRun);
  // Suppressed while stalled so the ID rollback never sees a load bubble and a stall at once
  assign w_stall_ld = w_hazard & (r_state == StRun) & ~w_stall & ~i_jmp_purge_ma;

  always_comb begin
    // Flush pre-charges stall_q so leaving FLUSH does not look like a new stall episode
    w_stall_q_d     = w_stall | w_rst_pipe;
    w_stall_ld_ex_d = r_stall_ld_ex;
    if (w_rst_pipe) begin
      w_stall_ld_ex_d = 1'b0;
    end else if (!w_stall) begin
      w_stall_ld_ex_d = w_stall_ld;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= RstState;
      r_cnt         <= '0;
      r_stall_q     <= 1'b1;
      r_stall_ld_ex <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_stall_q     <= w_stall_q_d;
      r_stall_ld_ex <= w_stall_ld_ex_d;
    end
  end

  assign o_stall       = w_stall;
  assign o_stall_1shot = w_stall & ~r_stall_q;
  assign o_stall_dly   = r_stall_q;
  assign o_stall_ld    = w_stall_ld;
  assign o_stall_ld_ex = r_stall_ld_ex;
  assign o_rst_pipe    = w_rst_pipe;
  assign o_cpu_running = (r_state == StRun);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; output vector order is
// {stall, stall_1shot, stall_dly, stall_ld, stall_ld_ex, rst_pipe, cpu_running}.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, dmem;
  logic [4:0] rs1, rs2, rd;
  logic       v1, v2, ld, wbk, jmp;
  logic       stall, stall_1shot, stall_dly, stall_ld, stall_ld_ex, rst_pipe, running;
  logic [6:0] obs;
  logic [6:0] exp_v;
  int         errs   = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign obs = {stall, stall_1shot, stall_dly, stall_ld, stall_ld_ex, rst_pipe, running};

  pipe_stall_ctrl #(
    .FLUSH_CYCLES (4),
    .DRAIN_CYCLES (3),
    .BOOT_RUN     (1'b0)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cpu_start      (start),
    .i_cpu_stop       (stop),
    .i_dmem_wait      (dmem),
    .i_inst_rs1_id    (rs1),
    .i_inst_rs2_id    (rs2),
    .i_inst_rs1_valid (v1),
    .i_inst_rs2_valid (v2),
    .i_cmd_ld_ex      (ld),
    .i_rd_adr_ex      (rd),
    .i_wbk_rd_reg_ex  (wbk),
    .i_jmp_purge_ma   (jmp),
    .o_stall          (stall),
    .o_stall_1shot    (stall_1shot),
    .o_stall_dly      (stall_dly),
    .o_stall_ld       (stall_ld),
    .o_stall_ld_ex    (stall_ld_ex),
    .o_rst_pipe       (rst_pipe),
    .o_cpu_running    (running)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 0; stop = 0; dmem = 0; ld = 0; rd = 0; wbk = 0;
    rs1 = 0; rs2 = 0; v1 = 0; v2 = 0; jmp = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clr();
    cyc();
    cyc();
    @(negedge clk);
    exp_v = 7'b1010000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL reset_state got=%b want=%b", obs, exp_v); end
    cyc();
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_v = 7'b1010000; checks++;
      if (obs !== exp_v) begin errs++; $display("FAIL halt_idle[%0d] got=%b want=%b", i, obs, exp_v); end
      cyc();
    end
  endtask

  task automatic test_start();
    start = 1;
    @(negedge clk);
    exp_v = 7'b1010000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL start_sampled got=%b want=%b", obs, exp_v); end
    cyc();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = 7'b1010010; checks++;
      if (obs !== exp_v) begin errs++; $display("FAIL flush[%0d] got=%b want=%b", i, obs, exp_v); end
      cyc();
    end
    @(negedge clk);
    exp_v = 7'b0010001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL run_first got=%b want=%b", obs, exp_v); end
    cyc();
    @(negedge clk);
    exp_v = 7'b0000001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL run_settled got=%b want=%b", obs, exp_v); end
    cyc();
  endtask

  task automatic test_load_use();
    ld = 1; rd = 5; wbk = 1; rs2 = 5; v2 = 1;
    @(negedge clk);
    exp_v = 7'b0001001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_use_rs2 got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
    @(negedge clk);
    exp_v = 7'b0000101; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_ex_set got=%b want=%b", obs, exp_v); end
    cyc();
    @(negedge clk);
    exp_v = 7'b0000001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_ex_clear got=%b want=%b", obs, exp_v); end
    cyc();
    ld = 1; rd = 0; wbk = 1; rs2 = 0; v2 = 1;
    @(negedge clk);
    exp_v = 7'b0000001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_rd_zero got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
    ld = 1; rd = 5; wbk = 1; rs2 = 5; v2 = 0;
    @(negedge clk);
    exp_v = 7'b0000001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_rs2_invalid got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
    ld = 1; rd = 7; wbk = 1; rs1 = 7; v1 = 1; rs2 = 7;
    @(negedge clk);
    exp_v = 7'b0001001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_use_rs1 got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
    @(negedge clk);
    exp_v = 7'b0000101; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_ex_rs1 got=%b want=%b", obs, exp_v); end
    cyc();
    ld = 1; rd = 7; wbk = 0; rs1 = 7; v1 = 1;
    @(negedge clk);
    exp_v = 7'b0000001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_no_wbk got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
  endtask

  task automatic test_hazard_mask();
    ld = 1; rd = 9; wbk = 1; rs2 = 9; v2 = 1; jmp = 1;
    @(negedge clk);
    exp_v = 7'b0000001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_jmp_purge got=%b want=%b", obs, exp_v); end
    cyc();
    jmp = 0; dmem = 1;
    @(negedge clk);
    exp_v = 7'b1100001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_dmem_wait got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
    @(negedge clk);
    exp_v = 7'b0010001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL wait_release got=%b want=%b", obs, exp_v); end
    cyc();
    ld = 1; rd = 9; wbk = 1; rs2 = 9; v2 = 1;
    @(negedge clk);
    exp_v = 7'b0001001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_before_wait got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
    dmem = 1;
    @(negedge clk);
    exp_v = 7'b1100101; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_ex_in_wait got=%b want=%b", obs, exp_v); end
    cyc();
    dmem = 0;
    @(negedge clk);
    exp_v = 7'b0010101; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_ex_held got=%b want=%b", obs, exp_v); end
    cyc();
    @(negedge clk);
    exp_v = 7'b0000001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_ex_release got=%b want=%b", obs, exp_v); end
    cyc();
  endtask

  task automatic test_dmem_wait();
    logic [6:0] seq [5];
    seq[0] = 7'b1100001; seq[1] = 7'b1010001; seq[2] = 7'b1010001;
    seq[3] = 7'b0010001; seq[4] = 7'b0000001;
    for (int i = 0; i < 5; i++) begin
      dmem = (i < 3);
      @(negedge clk);
      checks++;
      if (obs !== seq[i]) begin errs++; $display("FAIL dmem_wait_t%0d got=%b want=%b", i, obs, seq[i]); end
      cyc();
    end
    dmem = 0;
  endtask

  task automatic test_stop_drain();
    stop = 1;
    @(negedge clk);
    exp_v = 7'b0000001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL stop_sampled got=%b want=%b", obs, exp_v); end
    cyc();
    stop = 0;
    @(negedge clk);
    exp_v = 7'b1100000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL drain_0 got=%b want=%b", obs, exp_v); end
    cyc();
    @(negedge clk);
    exp_v = 7'b1010000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL drain_1 got=%b want=%b", obs, exp_v); end
    cyc();
    start = 1;
    @(negedge clk);
    exp_v = 7'b1010000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL drain_2 got=%b want=%b", obs, exp_v); end
    cyc();
    @(negedge clk);
    exp_v = 7'b1010000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL halt_after_drain got=%b want=%b", obs, exp_v); end
    cyc();
    start = 0;
    @(negedge clk);
    exp_v = 7'b1010010; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL flush_1st got=%b want=%b", obs, exp_v); end
    cyc();
    stop = 1;
    @(negedge clk);
    exp_v = 7'b1010010; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL flush_2nd_stop got=%b want=%b", obs, exp_v); end
    cyc();
    stop = 0;
    @(negedge clk);
    exp_v = 7'b1010000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL flush_aborted got=%b want=%b", obs, exp_v); end
    cyc();
    start = 1; stop = 1;
    @(negedge clk);
    exp_v = 7'b1010000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL start_stop_halt got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_v = 7'b1010000; checks++;
      if (obs !== exp_v) begin errs++; $display("FAIL still_halt[%0d] got=%b want=%b", i, obs, exp_v); end
      cyc();
    end
  endtask

  task automatic test_reset_mid_drain();
    ld = 1; rd = 5; wbk = 1; rs2 = 5; v2 = 1; stop = 1;
    @(negedge clk);
    exp_v = 7'b0001001; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL ld_with_stop got=%b want=%b", obs, exp_v); end
    cyc();
    clr();
    @(negedge clk);
    exp_v = 7'b1100100; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL drain_ld_ex got=%b want=%b", obs, exp_v); end
    cyc();
    rst_n = 0;
    @(negedge clk);
    exp_v = 7'b1010100; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL drain_ld_ex_hold got=%b want=%b", obs, exp_v); end
    cyc();
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_v = 7'b1010000; checks++;
      if (obs !== exp_v) begin errs++; $display("FAIL reset_mid_drain[%0d] got=%b want=%b", i, obs, exp_v); end
      cyc();
    end
  endtask

  task automatic test_reset_mid_flush();
    start = 1;
    @(negedge clk);
    exp_v = 7'b1010000; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL restart got=%b want=%b", obs, exp_v); end
    cyc();
    start = 0;
    @(negedge clk);
    exp_v = 7'b1010010; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL flush_a got=%b want=%b", obs, exp_v); end
    cyc();
    rst_n = 0;
    @(negedge clk);
    exp_v = 7'b1010010; checks++;
    if (obs !== exp_v) begin errs++; $display("FAIL flush_b got=%b want=%b", obs, exp_v); end
    cyc();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = 7'b1010000; checks++;
      if (obs !== exp_v) begin errs++; $display("FAIL reset_mid_flush[%0d] got=%b want=%b", i, obs, exp_v); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_load_use();
    test_hazard_mask();
    test_dmem_wait();
    test_stop_drain();
    test_start();
    test_reset_mid_drain();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
